// File: rtl/dmac_pkg.sv
// Shared types and constants for the DMAC write engine.
// State encoding, AXI field values and burst/page limits.
package dmac_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_AW,
      S_W,
      S_B
   } state_t;

   localparam logic [2:0]  SIZE_4B    = 3'b010;
   localparam logic [1:0]  BURST_INCR = 2'b01;
   localparam logic [1:0]  RESP_OKAY  = 2'b00;
   localparam int          MAX_BURST  = 16;
   localparam int          PAGE_BITS  = 12;
   localparam logic [12:0] PAGE_BYTES = 13'h1000;

endpackage

// File: rtl/dmac_burst_calc.sv
// Burst sizing: min(remaining, max burst, beats left in 4 KB page).
// Pure combinational; result is the AXI awlen (beats-1).
module dmac_burst_calc
   import dmac_pkg::*;
#(
   parameter int REM_W = 14,
   parameter int MAXB  = MAX_BURST
) (
   input  logic [PAGE_BITS-1:0] i_addr_lo,
   input  logic [REM_W-1:0]     i_rem,
   output logic [3:0]           o_awlen
);

   localparam int CW = (REM_W > 11) ? REM_W : 11;

   logic [10:0] w_page_beats;
   logic [4:0]  w_beats;

   // pick the smallest of the three limits
   always_comb begin
      w_page_beats = 11'((PAGE_BYTES - {1'b0, i_addr_lo}) >> 2);
      w_beats      = 5'(MAXB);
      if (CW'(i_rem) < CW'(MAXB))
         w_beats = i_rem[4:0];
      if (CW'(w_page_beats) < CW'(w_beats))
         w_beats = w_page_beats[4:0];
      o_awlen = 4'(w_beats - 5'd1);
   end

endmodule

// File: rtl/dmac_wr_engine.sv
// DMAC write engine: drains the data FIFO into AXI write bursts.
// One burst outstanding at a time; bursts never cross 4 KB.
module dmac_wr_engine #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int LEN_WIDTH  = 16,
   parameter int MAX_BURST  = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start_i,
   input  logic [ADDR_WIDTH-1:0] dst_addr_i,
   input  logic [LEN_WIDTH-1:0]  byte_len_i,
   output logic                  done_o,
   output logic                  err_o,
   input  logic                  fifo_empty_i,
   output logic                  fifo_rden_o,
   input  logic [DATA_WIDTH-1:0] fifo_rdata_i,
   output logic [ADDR_WIDTH-1:0] awaddr_o,
   output logic [3:0]            awlen_o,
   output logic [2:0]            awsize_o,
   output logic [1:0]            awburst_o,
   output logic                  awvalid_o,
   input  logic                  awready_i,
   output logic [DATA_WIDTH-1:0] wdata_o,
   output logic [3:0]            wstrb_o,
   output logic                  wlast_o,
   output logic                  wvalid_o,
   input  logic                  wready_i,
   input  logic [1:0]            bresp_i,
   input  logic                  bvalid_i,
   output logic                  bready_o
);

   import dmac_pkg::*;

   localparam int REM_W = LEN_WIDTH - 2;

   state_t                r_state;
   state_t                w_next;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [ADDR_WIDTH-1:0] r_awaddr;
   logic [REM_W-1:0]      r_rem;
   logic [3:0]            r_awlen;
   logic [3:0]            r_cnt;
   logic                  r_err;

   logic [PAGE_BITS-1:0]  w_calc_lo;
   logic [REM_W-1:0]      w_calc_rem;
   logic [3:0]            w_awlen;
   logic [4:0]            w_burst_beats;
   logic                  w_idle_start;
   logic                  w_aw_hs;
   logic                  w_w_hs;
   logic                  w_last_hs;
   logic                  w_b_hs;

   // first burst is sized from the inputs, later ones from the registers
   always_comb begin
      w_calc_lo  = r_addr[PAGE_BITS-1:0];
      w_calc_rem = r_rem;
      if (r_state == S_IDLE) begin
         w_calc_lo  = dst_addr_i[PAGE_BITS-1:0];
         w_calc_rem = byte_len_i[LEN_WIDTH-1:2];
      end
   end

   dmac_burst_calc #(
      .REM_W (REM_W),
      .MAXB  (MAX_BURST)
   ) u_calc (
      .i_addr_lo (w_calc_lo),
      .i_rem     (w_calc_rem),
      .o_awlen   (w_awlen)
   );

   // state register
   always_ff @(posedge clk) begin
      if (!rst_n)
         r_state <= S_IDLE;
      else
         r_state <= w_next;
   end

   // next-state and handshake outputs
   always_comb begin
      w_next    = r_state;
      done_o    = 1'b0;
      awvalid_o = 1'b0;
      wvalid_o  = 1'b0;
      bready_o  = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            done_o = 1'b1;
            if (start_i && (byte_len_i != '0))
               w_next = S_AW;
         end
         S_AW: begin
            awvalid_o = 1'b1;
            if (awready_i)
               w_next = S_W;
         end
         S_W: begin
            wvalid_o = !fifo_empty_i;
            if (!fifo_empty_i && wready_i && (r_cnt == 4'd0))
               w_next = S_B;
         end
         S_B: begin
            bready_o = 1'b1;
            if (bvalid_i)
               w_next = (r_rem != '0) ? S_AW : S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
      wlast_o     = wvalid_o && (r_cnt == 4'd0);
      fifo_rden_o = wvalid_o && wready_i;
   end

   assign w_idle_start  = (r_state == S_IDLE) && start_i;
   assign w_aw_hs       = awvalid_o && awready_i;
   assign w_w_hs        = wvalid_o && wready_i;
   assign w_last_hs     = w_w_hs && wlast_o;
   assign w_b_hs        = bready_o && bvalid_i;
   assign w_burst_beats = {1'b0, r_awlen} + 5'd1;

   // address, remaining beats, burst registers and sticky error
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_addr   <= '0;
         r_rem    <= '0;
         r_awaddr <= '0;
         r_awlen  <= '0;
         r_cnt    <= '0;
         r_err    <= 1'b0;
      end else begin
         if (w_idle_start) begin
            r_err <= 1'b0;
            if (byte_len_i != '0) begin
               r_addr <= dst_addr_i;
               r_rem  <= byte_len_i[LEN_WIDTH-1:2];
            end
         end
         if ((w_next == S_AW) && (r_state != S_AW)) begin
            r_awaddr <= (r_state == S_IDLE) ? dst_addr_i : r_addr;
            r_awlen  <= w_awlen;
         end
         if (w_aw_hs)
            r_cnt <= r_awlen;
         if (w_w_hs)
            r_cnt <= r_cnt - 4'd1;
         if (w_last_hs) begin
            r_addr <= r_addr + ADDR_WIDTH'({w_burst_beats, 2'b00});
            r_rem  <= r_rem - REM_W'(w_burst_beats);
         end
         if (w_b_hs && (bresp_i != RESP_OKAY))
            r_err <= 1'b1;
      end
   end

   assign err_o     = r_err;
   assign awaddr_o  = r_awaddr;
   assign awlen_o   = r_awlen;
   assign awsize_o  = SIZE_4B;
   assign awburst_o = BURST_INCR;
   assign wdata_o   = fifo_rdata_i;
   assign wstrb_o   = 4'hF;

endmodule

// File: doc/dmac_wr_engine.md
Name: dmac_wr_engine

Overview:
DMA write-side engine that drains the DMAC data FIFO and writes its contents to memory over an AXI4-style write interface (AW/W/B channels).
It sits between the FIFO read port and the DMAC's AXI master write channels.
The DMAC control FSM supplies a destination address and byte length, then starts the engine.
The engine splits the transfer into bursts of at most MAX_BURST beats, never crossing a 4 KB boundary, and reports completion once all write responses have returned.

Parameters:
DATA_WIDTH, 32, data beat width in bits; fixed at 32 (4-byte beats).
ADDR_WIDTH, 32, AXI address width.
LEN_WIDTH, 16, width of byte-length input.
MAX_BURST, 16, maximum beats per burst (power of two, at most 16).

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
start_i  in  1  start pulse; accepted only while done_o=1
dst_addr_i  in  ADDR_WIDTH  destination byte address, 4-byte aligned, sampled on accepted start
byte_len_i  in  LEN_WIDTH  transfer length in bytes, multiple of 4, sampled on accepted start
done_o  out  1  high while idle (no transfer in progress)
err_o  out  1  sticky: some BRESP!=OKAY during the last transfer; cleared on accepted start
fifo_empty_i  in  1  FIFO empty flag
fifo_rden_o  out  1  FIFO pop
fifo_rdata_i  in  DATA_WIDTH  FIFO head data (show-ahead, valid whenever !fifo_empty_i)
awaddr_o  out  ADDR_WIDTH  burst start address
awlen_o  out  4  beats-1
awsize_o  out  3  constant 3'b010
awburst_o  out  2  constant 2'b01 (INCR)
awvalid_o  out  1  AW valid
awready_i  in  1  AW ready
wdata_o  out  DATA_WIDTH  write data (= fifo_rdata_i)
wstrb_o  out  4  constant 4'hF
wlast_o  out  1  last beat of burst
wvalid_o  out  1  W valid
wready_i  in  1  W ready
bresp_i  in  2  write response
bvalid_i  in  1  B valid
bready_o  out  1  B ready

Behaviour:
- Reset values:
  - done_o=1; err_o=0.
  - awvalid_o, wvalid_o, bready_o, fifo_rden_o, wlast_o = 0.
  - awaddr_o=0; awlen_o=0.
  - FSM in IDLE.
- FSM states: IDLE, AW, W, B.
- IDLE:
  - On start_i with byte_len_i != 0: latch addr and remaining beats (byte_len_i>>2), clear err_o, go to AW.
  - On start_i with byte_len_i == 0: clear err_o, stay in IDLE; done_o stays 1.
  - start_i outside IDLE is ignored.
- Burst length:
  - beats = min(remaining, MAX_BURST, (4096 - addr[11:0])>>2).
  - Computed combinationally from the registered addr and remaining.
  - Registered into awaddr_o/awlen_o on entry to AW.
- AW:
  - awvalid_o=1; awaddr_o and awlen_o stay stable until awready_i.
  - On handshake: load beat counter = awlen, go to W.
- W:
  - wvalid_o = !fifo_empty_i.
  - fifo_rden_o = wvalid_o & wready_i (exactly one pop per accepted beat).
  - wlast_o = (beat counter == 0) & wvalid_o.
  - The beat counter decrements on each accepted beat.
  - On the accepted wlast beat: addr += beats*4, remaining -= beats, go to B.
- B:
  - bready_o=1.
  - On bvalid_i: if bresp_i != 0 set err_o.
  - Then go to AW if remaining != 0, else IDLE (done_o rises the cycle after the last B handshake).
- Only one outstanding burst; AW is never issued before the previous B is received.
- FIFO empty mid-burst: wvalid_o drops, no pop, burst resumes when data arrives; no timeout.
- AXI stability: once asserted, awvalid_o stays high until handshake. wvalid_o may only fall while wready_i is low or after a handshake. Because data is sourced from the FIFO head, wdata_o is stable while wvalid_o is high.
- Synchronous reset mid-transfer returns to IDLE next cycle and drops all valids. Outstanding AXI transactions are the system's responsibility.
- Address arithmetic wraps modulo 2^ADDR_WIDTH. Remaining-beat count is LEN_WIDTH-2 bits.

Decomposition:
- A shared dmac_pkg holds:
  - the state enum typedef (IDLE/AW/W/B);
  - the AXI constants (SIZE_4B=3'b010, BURST_INCR=2'b01, RESP_OKAY=2'b00);
  - MAX_BURST and the 4 KB boundary constant (12 bits).
- Natural sub-module: dmac_burst_calc, the combinational beats/awlen computation from addr, remaining and MAX_BURST.
- The FSM and counters stay in the top module.

Test Plan:
- start addr=0x1000, len=64, FIFO preloaded with 16 words, ready always 1 -> one AW (addr 0x1000, awlen 15), 16 W beats in order, wlast on beat 16, 16 pops, one B, done_o=1, err_o=0.
- addr=0x0FF8, len=32 -> two bursts: AW 0x0FF8/awlen 1, then AW 0x1000/awlen 5; no 4 KB crossing.
- len=80 at 0x2000 -> bursts of 16 and 4 beats, second AW issued only after the first B.
- FIFO empty for 5 cycles after beat 3 -> wvalid_o=0 and fifo_rden_o=0 during the gap; beats 4..16 continue in order with no duplicated or lost data.
- wready_i toggling and awready_i delayed 3 cycles -> awaddr_o/awlen_o stable while awvalid_o=1; pop count equals beats accepted.
- bresp_i=2'b10 on the first of two bursts -> transfer completes, err_o=1 sticky; next start clears it. Additionally: a start with len=0 leaves done_o=1 and issues no AW; rst_n=0 during W -> all valids 0 and done_o=1 the next cycle.
